revo_word_tracker: RTL and testbench

Receive-side companion to the 509 MHz clock and revolution-marker generator. Consumes the 8-bit revo words recovered by an ISERDES at the 127 MHz word clock. Finds the marker's rising edge and its bit phase, then flywheels a 0..1279 word counter locked to the revolution period. Provides a one-word revo strobe, lock status and a miss counter to downstream bunch-timing logic.

---
 rtl/revo_word_tracker.sv | 176 +++++++++++++++++
 tb/tb_revo_word_tracker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/revo_word_tracker.sv
// Receive-side revolution tracker: locates the revo marker edge and bit phase in
// deserialized words, then flywheels a word counter locked to the revolution period.
module revo_word_tracker #(
    parameter int WORDS_PER_REVO = 1280,
    parameter int WIDTH          = 8,
    parameter int LOCK_COUNT     = 4,
    parameter int UNLOCK_ERRORS  = 3
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  word_in,
    output logic                              revo_out,
    output logic                              locked,
    output logic [$clog2(WORDS_PER_REVO)-1:0] word_counter,
    output logic [$clog2(WIDTH)-1:0]          phase,
    output logic [15:0]                       missed_count
);

    localparam int CW = $clog2(WORDS_PER_REVO);
    localparam int PW = $clog2(WIDTH);
    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(UNLOCK_ERRORS + 1);

    localparam logic [CW-1:0] C_LAST     = CW'(WORDS_PER_REVO - 1);
    localparam logic [GW-1:0] GOOD_FINAL = GW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] ERR_FINAL  = EW'(UNLOCK_ERRORS - 1);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Scans LSB upward so the last hit is the MSB-most edge; returns {mark, position}.
    function automatic logic [PW:0] find_edge(input logic prev, input logic [WIDTH-1:0] w);
        logic [WIDTH:0]  stream;
        logic            found;
        logic [PW-1:0]   pos;
        logic            hit;
        stream = {prev, w};
        found  = 1'b0;
        pos    = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            hit   = stream[i] & ~stream[i+1];
            pos   = hit ? PW'(WIDTH - 1 - i) : pos;
            found = found | hit;
        end
        return {found, pos};
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          state_r;
    logic [CW-1:0]   c_r;
    logic [GW-1:0]   good_r;
    logic [EW-1:0]   err_r;
    logic            prev_bit_r;
    logic [PW-1:0]   phase_r;
    logic [15:0]     missed_r;
    logic            revo_r;
    logic            locked_r;
    logic [CW-1:0]   word_counter_r;

    logic [PW:0]     edge_s;
    logic            mark_s;
    logic [PW-1:0]   pos_s;
    logic            c_zero_s;
    logic            good_mark_s;
    logic [CW-1:0]   c_inc_s;

    // Per-word edge detection and counter helpers.
    always_comb begin
        edge_s      = find_edge(prev_bit_r, word_in);
        mark_s      = edge_s[PW];
        pos_s       = edge_s[PW-1:0];
        c_zero_s    = (c_r == {CW{1'b0}});
        good_mark_s = mark_s && c_zero_s && (pos_s == phase_r);
        c_inc_s     = (c_r == C_LAST) ? {CW{1'b0}} : c_r + CW'(1);
    end

    // Search / confirm / locked state machine with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= SEARCH;
            c_r            <= {CW{1'b0}};
            good_r         <= {GW{1'b0}};
            err_r          <= {EW{1'b0}};
            prev_bit_r     <= 1'b0;
            phase_r        <= {PW{1'b0}};
            missed_r       <= 16'd0;
            revo_r         <= 1'b0;
            locked_r       <= 1'b0;
            word_counter_r <= {CW{1'b0}};
        end else begin
            prev_bit_r     <= word_in[0];
            word_counter_r <= c_r;
            revo_r         <= 1'b0;
            case (state_r)
                SEARCH: begin
                    locked_r <= 1'b0;
                    if (mark_s) begin
                        phase_r <= pos_s;
                        c_r     <= CW'(1);
                        good_r  <= GW'(1);
                        state_r <= CONFIRM;
                    end else begin
                        c_r <= {CW{1'b0}};
                    end
                end
                CONFIRM: begin
                    if (good_mark_s) begin
                        c_r    <= c_inc_s;
                        good_r <= good_r + GW'(1);
                        if (good_r == GOOD_FINAL) begin
                            state_r  <= LOCKED;
                            err_r    <= {EW{1'b0}};
                            revo_r   <= 1'b1;
                            locked_r <= 1'b1;
                        end else begin
                            state_r <= CONFIRM;
                        end
                    end else if (mark_s) begin
                        // Misplaced or wrong-phase mark: treat it as a fresh first mark.
                        phase_r <= pos_s;
                        c_r     <= CW'(1);
                        good_r  <= GW'(1);
                    end else if (c_zero_s) begin
                        state_r <= SEARCH;
                        c_r     <= {CW{1'b0}};
                        good_r  <= {GW{1'b0}};
                    end else begin
                        c_r <= c_inc_s;
                    end
                end
                LOCKED: begin
                    if (good_mark_s) begin
                        err_r  <= {EW{1'b0}};
                        c_r    <= c_inc_s;
                        revo_r <= 1'b1;
                    end else if (c_zero_s || mark_s) begin
                        missed_r <= sat_inc16(missed_r);
                        if (err_r == ERR_FINAL) begin
                            state_r  <= SEARCH;
                            c_r      <= {CW{1'b0}};
                            err_r    <= {EW{1'b0}};
                            good_r   <= {GW{1'b0}};
                            locked_r <= 1'b0;
                        end else begin
                            err_r  <= err_r + EW'(1);
                            c_r    <= c_inc_s;
                            revo_r <= c_zero_s;
                        end
                    end else begin
                        c_r <= c_inc_s;
                    end
                end
                default: begin
                    state_r  <= SEARCH;
                    c_r      <= {CW{1'b0}};
                    good_r   <= {GW{1'b0}};
                    err_r    <= {EW{1'b0}};
                    locked_r <= 1'b0;
                end
            endcase
        end
    end

    assign revo_out     = revo_r;
    assign locked       = locked_r;
    assign word_counter = word_counter_r;
    assign phase        = phase_r;
    assign missed_count = missed_r;

endmodule

// File: tb/tb_revo_word_tracker.sv
// Scoreboard bench for revo_word_tracker: a behavioural model queues the expected
// outputs for each driven word and they are compared one clock later.
module tb_revo_word_tracker;

    localparam int WPR = 1280;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  word_in = 8'h00;
    logic        revo_out;
    logic        locked;
    logic [10:0] word_counter;
    logic [2:0]  phase;
    logic [15:0] missed_count;

    int checks   = 0;
    int failures = 0;

    revo_word_tracker dut (
        .clock        (clock),
        .reset        (reset),
        .word_in      (word_in),
        .revo_out     (revo_out),
        .locked       (locked),
        .word_counter (word_counter),
        .phase        (phase),
        .missed_count (missed_count)
    );

    always #4 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_state;   // 0 search, 1 confirm, 2 locked
    int          m_c, m_good, m_err;
    logic        m_prev;
    logic [2:0]  m_phase;
    logic [15:0] m_missed;
    logic [31:0] exp_q[$];

    // Per-revolution observations
    logic        r0_revo, r0_locked;
    logic [10:0] r0_wc;
    logic [2:0]  r0_phase;
    int          pulses, off_pulses;

    task automatic model_reset();
        m_state = 0; m_c = 0; m_good = 0; m_err = 0;
        m_prev = 1'b0; m_phase = 3'd0; m_missed = 16'd0;
    endtask

    task automatic model_step(input logic [7:0] w);
        logic [7:0] e;
        logic       mk;
        logic       gm;
        logic       m_revo;
        int         p;
        int         c_now;
        e  = w & ~{m_prev, w[7:1]};
        mk = |e;
        p  = 0;
        for (int i = 0; i < 8; i++) if (e[i]) p = 7 - i;
        c_now  = m_c;
        gm     = mk && (c_now == 0) && (p == int'(m_phase));
        m_prev = w[0];
        case (m_state)
            0: if (mk) begin m_phase = 3'(p); m_c = 1; m_good = 1; m_state = 1; end
            1: begin
                if (gm) begin
                    m_good++; m_c = 1;
                    if (m_good == 4) begin m_state = 2; m_err = 0; end
                end else if (mk) begin
                    m_phase = 3'(p); m_c = 1; m_good = 1;
                end else if (c_now == 0) begin
                    m_state = 0; m_c = 0;
                end else begin
                    m_c = (c_now + 1) % WPR;
                end
            end
            default: begin
                if (gm) begin
                    m_err = 0; m_c = 1;
                end else if (c_now == 0 || mk) begin
                    if (m_missed != 16'hFFFF) m_missed++;
                    m_err++;
                    if (m_err == 3) begin m_state = 0; m_c = 0; m_err = 0; end
                    else m_c = (c_now + 1) % WPR;
                end else begin
                    m_c = (c_now + 1) % WPR;
                end
            end
        endcase
        m_revo = (c_now == 0) && (m_state == 2);
        exp_q.push_back({m_revo, (m_state == 2), 11'(c_now), m_phase, m_missed});
    endtask

    task automatic drive_word(input logic [7:0] w);
        logic [31:0] obs;
        word_in = w;
        model_step(w);
        @(posedge clock);
        #1;
        obs = {revo_out, locked, word_counter, phase, missed_count};
        if (exp_q.size() == 0) check_eq("queue_empty", 32'd1, 32'd0);
        else check_eq("outs", obs, exp_q.pop_front());
        @(negedge clock);
    endtask

    task automatic do_async_reset();
        #2 reset = 1'b1;
        #1;
        check_eq("rst_revo", {31'd0, revo_out}, 32'd0);
        check_eq("rst_locked", {31'd0, locked}, 32'd0);
        check_eq("rst_wc", {21'd0, word_counter}, 32'd0);
        check_eq("rst_phase", {29'd0, phase}, 32'd0);
        check_eq("rst_missed", {16'd0, missed_count}, 32'd0);
        model_reset();
        exp_q.delete();
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_revo(input logic [7:0] mw, input logic [7:0] nw, input int inj, input int rst_at);
        logic [7:0] w;
        pulses = 0;
        off_pulses = 0;
        for (int i = 0; i < WPR; i++) begin
            if (i == rst_at) begin
                do_async_reset();
                return;
            end
            w = (i == 0) ? mw : (i == 1) ? nw : (i == inj) ? 8'hFF : 8'h00;
            drive_word(w);
            if (i == 0) begin
                r0_revo = revo_out; r0_locked = locked; r0_wc = word_counter; r0_phase = phase;
            end
            if (revo_out) begin
                pulses++;
                if (i != 0) off_pulses++;
            end
        end
    endtask

    task automatic lock_ff(input string tag);
        for (int r = 0; r < 3; r++) send_revo(8'hFF, 8'h00, -1, -1);
        check_eq({tag, "_prelock"}, {31'd0, locked}, 32'd0);
        send_revo(8'hFF, 8'h00, -1, -1);
        check_eq({tag, "_lock"}, {31'd0, r0_locked}, 32'd1);
        check_eq({tag, "_lock_revo"}, {31'd0, r0_revo}, 32'd1);
    endtask

    initial begin
        model_reset();
        repeat (10) @(negedge clock);
        check_eq("init_outs", {revo_out, locked, word_counter, phase, missed_count}, 32'd0);
        reset = 1'b0;

        // Aligned marker: lock on word 3840, phase 0, one pulse per revolution
        lock_ff("aligned");
        check_eq("aligned_phase", {29'd0, r0_phase}, 32'd0);
        check_eq("aligned_wc", {21'd0, r0_wc}, 32'd0);
        send_revo(8'hFF, 8'h00, -1, -1);
        check_eq("flywheel_pulses", pulses, 32'd1);
        check_eq("flywheel_offpulses", off_pulses, 32'd0);
        check_eq("flywheel_wc", {21'd0, r0_wc}, 32'd0);

        // Misaligned marker straddling two words
        do_async_reset();
        for (int r = 0; r < 3; r++) send_revo(8'b00000111, 8'b11111000, -1, -1);
        check_eq("mis_prelock", {31'd0, locked}, 32'd0);
        send_revo(8'b00000111, 8'b11111000, -1, -1);
        check_eq("mis_lock", {31'd0, r0_locked}, 32'd1);
        check_eq("mis_revo", {31'd0, r0_revo}, 32'd1);
        check_eq("mis_phase", {29'd0, r0_phase}, 32'd5);

        // Single omitted marker is flywheeled
        do_async_reset();
        lock_ff("relock1");
        send_revo(8'h00, 8'h00, -1, -1);
        check_eq("omit1_revo", {31'd0, r0_revo}, 32'd1);
        check_eq("omit1_locked", {31'd0, locked}, 32'd1);
        check_eq("omit1_missed", {16'd0, missed_count}, 32'd1);
        send_revo(8'hFF, 8'h00, -1, -1);
        check_eq("omit1_recover", {31'd0, r0_revo}, 32'd1);

        // Three omitted markers drop lock, then relock
        send_revo(8'h00, 8'h00, -1, -1);
        send_revo(8'h00, 8'h00, -1, -1);
        check_eq("omit3_still", {31'd0, locked}, 32'd1);
        send_revo(8'h00, 8'h00, -1, -1);
        check_eq("omit3_drop", {31'd0, r0_locked}, 32'd0);
        check_eq("omit3_norevo", {31'd0, r0_revo}, 32'd0);
        check_eq("omit3_missed", {16'd0, missed_count}, 32'd4);
        lock_ff("relock2");

        // Spurious mark mid-revolution
        send_revo(8'hFF, 8'h00, 640, -1);
        check_eq("inject_missed", {16'd0, missed_count}, 32'd5);
        check_eq("inject_locked", {31'd0, locked}, 32'd1);
        check_eq("inject_offpulses", off_pulses, 32'd0);
        send_revo(8'hFF, 8'h00, -1, -1);
        check_eq("inject_next_revo", {31'd0, r0_revo}, 32'd1);
        check_eq("inject_next_wc", {21'd0, r0_wc}, 32'd0);

        // Asynchronous reset mid-revolution, then fresh relock
        send_revo(8'hFF, 8'h00, -1, 700);
        lock_ff("relock3");
        check_eq("relock3_missed", {16'd0, missed_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
